// File: rtl/fb_scan_arb_if.sv
// Host write port and framebuffer RAM port of the scan-out arbiter.
//   host_req/host_addr/host_wdata -> host_gnt : host write handshake
//   mem_en/mem_we/mem_addr/mem_wdata, mem_rdata : single-port RAM bus
// slave  : the arbiter side (drives grant and RAM controls)
// master : the host + RAM side (drives requests and read data)
interface fb_scan_arb_if #(
  parameter int ADDR_W = 19,
  parameter int PIX_W  = 12
);
  logic              host_req;
  logic [ADDR_W-1:0] host_addr;
  logic [PIX_W-1:0]  host_wdata;
  logic              host_gnt;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [PIX_W-1:0]  mem_wdata;
  logic [PIX_W-1:0]  mem_rdata;

  modport slave (
    input  host_req, host_addr, host_wdata, mem_rdata,
    output host_gnt, mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output host_req, host_addr, host_wdata, mem_rdata,
    input  host_gnt, mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/fb_scan_arb.sv
// Framebuffer scan-out controller and RAM arbiter.
// Prefetches raster-order pixels into a FIFO and presents one pixel per
// active cycle, sharing the single RAM port with a host write port.
// Ports:
//   clk_pix, rst_pix_n : pixel clock, async active-low reset
//   sx, sy, de         : raster position / active strobe from timing gen
//   bus                : host write handshake + RAM bus (fb_scan_arb_if)
//   pix_data, pix_de   : registered pixel and its aligned active strobe
//   underflow          : sticky, set when de finds the FIFO empty
module fb_scan_arb #(
  parameter int H_ACT_PIX   = 640,
  parameter int V_ACT_LINES = 480,
  parameter int ADDR_W      = 19,
  parameter int PIX_W       = 12,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic             clk_pix,
  input  logic             rst_pix_n,
  input  logic [11:0]      sx,
  input  logic [11:0]      sy,
  input  logic             de,
  fb_scan_arb_if.slave     bus,
  output logic [PIX_W-1:0] pix_data,
  output logic             pix_de,
  output logic             underflow
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0]    DEPTH_L = (PTR_W+1)'(FIFO_DEPTH);
  localparam logic [PTR_W:0]    HALF_L  = (PTR_W+1)'(FIFO_DEPTH / 2);
  localparam logic [ADDR_W-1:0] FRAME_L = ADDR_W'(H_ACT_PIX * V_ACT_LINES);
  localparam logic [11:0]       VACT_L  = 12'(V_ACT_LINES);

  typedef enum logic [1:0] {WAIT_VB, PRIME, ACTIVE} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] fetch_cnt_q, fetch_cnt_d;
  logic [PTR_W:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic              inflight_q, inflight_d;
  logic [PIX_W-1:0]  pix_data_q, pix_data_d;
  logic              pix_de_q, pix_de_d;
  logic              underflow_q, underflow_d;
  logic [PIX_W-1:0]  fifo_mem [FIFO_DEPTH];

  logic           in_vb, flush, fetch_want, urgent, fetch_gnt, host_win;
  logic           empty, pop, push;
  logic [PTR_W:0] occ, level;

  // Raster order comes from fetch_cnt, so the horizontal position is not needed.
  logic unused_sx;
  assign unused_sx = ^sx;

  always_comb begin
    in_vb = (sy >= VACT_L);

    state_d = state_q;
    case (state_q)
      WAIT_VB: if (in_vb)  state_d = PRIME;
      PRIME:   if (!in_vb) state_d = ACTIVE;
      ACTIVE:  if (in_vb)  state_d = PRIME;
      default:             state_d = WAIT_VB;
    endcase

    // Flush on the edge that enters PRIME; the read issued this cycle is dropped.
    flush = (state_d == PRIME) && (state_q != PRIME);

    occ   = wr_ptr_q - rd_ptr_q;
    level = occ + {{PTR_W{1'b0}}, inflight_q};

    fetch_want = (state_q != WAIT_VB) && (level < DEPTH_L) && (fetch_cnt_q < FRAME_L);
    urgent     = fetch_want && (state_q == ACTIVE) && (occ < HALF_L);

    // Gated by reset so the RAM port is quiet while reset is held.
    fetch_gnt = rst_pix_n && (urgent || (!bus.host_req && fetch_want));
    host_win  = rst_pix_n && !urgent && bus.host_req;

    bus.mem_en    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.host_gnt  = 1'b0;
    if (fetch_gnt) begin
      bus.mem_en   = 1'b1;
      bus.mem_addr = fetch_cnt_q;
    end else if (host_win) begin
      bus.mem_en    = 1'b1;
      bus.mem_we    = 1'b1;
      bus.mem_addr  = bus.host_addr;
      bus.mem_wdata = bus.host_wdata;
      bus.host_gnt  = 1'b1;
    end

    empty = (occ == '0);
    pop   = de && !empty;
    push  = inflight_q && !flush;

    pix_data_d  = pop ? fifo_mem[rd_ptr_q[PTR_W-1:0]] : '0;
    pix_de_d    = de;
    underflow_d = underflow_q | (de & empty);

    wr_ptr_d    = flush ? '0 : wr_ptr_q + {{PTR_W{1'b0}}, push};
    rd_ptr_d    = flush ? '0 : rd_ptr_q + {{PTR_W{1'b0}}, pop};
    fetch_cnt_d = flush ? '0 : fetch_cnt_q + {{(ADDR_W-1){1'b0}}, fetch_gnt};
    inflight_d  = fetch_gnt && !flush;
  end

  always_ff @(posedge clk_pix or negedge rst_pix_n) begin
    if (!rst_pix_n) begin
      state_q     <= WAIT_VB;
      fetch_cnt_q <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      inflight_q  <= 1'b0;
      pix_data_q  <= '0;
      pix_de_q    <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      fetch_cnt_q <= fetch_cnt_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      inflight_q  <= inflight_d;
      pix_data_q  <= pix_data_d;
      pix_de_q    <= pix_de_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage needs no reset; the pointers define what is valid.
  always_ff @(posedge clk_pix) begin
    if (push) fifo_mem[wr_ptr_q[PTR_W-1:0]] <= bus.mem_rdata;
  end

  assign pix_data  = pix_data_q;
  assign pix_de    = pix_de_q;
  assign underflow = underflow_q;

endmodule
